// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file arbiter.
package regfile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr and wraps.
// Returns a one-hot grant and the binary index of the winner.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] winner
);

    // First requester found at or after ptr (modulo N) wins.
    always_comb begin
        gnt    = '0;
        winner = '0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned idx;
            idx = (32'(ptr) + k) % N;
            if (gnt == '0 && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file (sync write, comb read)
// between NUM_REQ requesters. Commands run IDLE -> ISSUE -> RESP; GNT
// pulses in ISSUE, DONE pulses in RESP with read data on RDATA.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned REG_SIZE  = 4,
    parameter int unsigned ADDR_SIZE = 3
) (
    input  logic                           CLK,
    input  logic                           CLR,
    input  logic [NUM_REQ-1:0]             REQ,
    input  logic [NUM_REQ-1:0]             WE,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   ADDR,
    input  logic [NUM_REQ*REG_SIZE-1:0]    WDATA,
    output logic [NUM_REQ-1:0]             GNT,
    output logic [NUM_REQ-1:0]             DONE,
    output logic [REG_SIZE-1:0]            RDATA,
    output logic                           BUSY,
    output logic                           RF_WrEn,
    output logic [ADDR_SIZE-1:0]           RF_WA,
    output logic [ADDR_SIZE-1:0]           RF_RA,
    output logic [REG_SIZE-1:0]            RF_DIN,
    input  logic [REG_SIZE-1:0]            RF_DOUT
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state, state_nx;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        win_idx;
    logic [NUM_REQ-1:0]   win_oh;
    logic                 take;
    logic                 sel_we;
    logic                 sel_ok;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [REG_SIZE-1:0]  sel_data;
    logic                 cmd_we;
    logic                 cmd_ok;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req    (REQ),
        .ptr    (ptr),
        .gnt    (win_oh),
        .winner (win_idx)
    );

    // Next state and the decision to accept a new command this cycle.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|REQ) begin
                    take     = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = RESP;
            RESP: begin
                if (|REQ) begin
                    take     = 1'b1;
                    state_nx = ISSUE;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Select the winner's command slice.
    always_comb begin
        sel_we   = WE[win_idx];
        sel_addr = ADDR[win_idx*ADDR_SIZE +: ADDR_SIZE];
        sel_data = WDATA[win_idx*REG_SIZE +: REG_SIZE];
        sel_ok   = (32'(sel_addr) < NUM_REGS);
    end

    // State register.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= state_nx;
    end

    // Command latch, registered RF port, GNT/DONE pulses, RDATA and pointer.
    // The RF_WA/RF_RA/RF_DIN registers double as the latched address/data,
    // loaded at the edge entering ISSUE and cleared at the edge leaving it.
    // DONE reuses the one-hot GNT register of the ISSUE cycle.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            ptr     <= '0;
            cmd_we  <= 1'b0;
            cmd_ok  <= 1'b0;
            GNT     <= '0;
            DONE    <= '0;
            RDATA   <= '0;
            RF_WrEn <= 1'b0;
            RF_WA   <= '0;
            RF_RA   <= '0;
            RF_DIN  <= '0;
        end else begin
            GNT     <= '0;
            DONE    <= '0;
            RF_WrEn <= 1'b0;
            RF_WA   <= '0;
            RF_RA   <= '0;
            RF_DIN  <= '0;
            if (take) begin
                cmd_we  <= sel_we;
                cmd_ok  <= sel_ok;
                GNT     <= win_oh;
                RF_WrEn <= sel_we & sel_ok;
                RF_WA   <= sel_addr;
                RF_RA   <= sel_addr;
                RF_DIN  <= sel_data;
                ptr     <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
            end
            if (state == ISSUE) begin
                DONE <= GNT;
                if (!cmd_we) RDATA <= cmd_ok ? RF_DOUT : '0;
            end
        end
    end

    assign BUSY = (state != IDLE);

endmodule
